// File: rtl/framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// framebuffer_scanout : 40x30 monochrome framebuffer -> VGA raster, one square
// cell of 2^CELL_SHIFT pixels per bit, snapshotted once per frame.
// Revision 1.0
// ============================================================================
module framebuffer_scanout #(
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter int          H_VISIBLE  = 640,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          V_VISIBLE  = 480,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33,
  parameter int          CELL_SHIFT = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pixel_tick,
  input  logic [1199:0] framebuffer,
  output logic          hsync,
  output logic          vsync,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int COLS    = 40;
  localparam int IDX_W   = 11;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [HW-1:0]    hcount_q, hcount_d;
  logic [VW-1:0]    vcount_q, vcount_d;
  logic [1199:0]    snap_q, snap_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             frame_start_q, frame_start_d;

  logic             h_last, v_last, visible, snap_load;
  logic [HW-1:0]    col;
  logic [VW-1:0]    row;
  logic [IDX_W-1:0] cell_idx;

  assign h_last    = (hcount_q == H_LAST);
  assign v_last    = (vcount_q == V_LAST);
  assign visible   = (hcount_q < H_VIS_END) && (vcount_q < V_VIS_END);
  assign col       = hcount_q >> CELL_SHIFT;
  assign row       = vcount_q >> CELL_SHIFT;
  // Column 0 is the MSB end of each 40-bit row; only consumed while visible.
  assign cell_idx  = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(COLS - 1) - IDX_W'(col);
  // Reload at the first blanking line so a whole visible frame uses one image.
  assign snap_load = pixel_tick && (hcount_q == '0) && (vcount_q == V_VIS_END);

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    snap_d        = snap_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    if (pixel_tick) begin
      if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? '0 : vcount_q + VW'(1);
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
      hsync_d       = !((hcount_q >= H_SYNC_BEG) && (hcount_q < H_SYNC_END));
      vsync_d       = !((vcount_q >= V_SYNC_BEG) && (vcount_q < V_SYNC_END));
      rgb_d         = visible ? (snap_q[cell_idx] ? FG_COLOR : BG_COLOR) : 12'h000;
      frame_start_d = h_last && v_last;
    end
    if (snap_load) begin
      snap_d = framebuffer;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      snap_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 12'h000;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      snap_q        <= snap_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync              = hsync_q;
  assign vsync              = vsync_q;
  assign {red, green, blue} = rgb_q;
  assign frame_start        = frame_start_q;

endmodule

`default_nettype wire
